// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   - STALL_W_DEF : default width of the stall bus (one bit per stage, IF = 0)
//   - DEPTH_W     : width of one REQ_DEPTH field (highest held stage index)
//   - BUBBLE_W    : width of the post-flush bubble down-counter
//   - PC_W        : redirect target width
//   - hz_state_e  : controller FSM state encodings
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int STALL_W_DEF = 6;
  localparam int DEPTH_W     = 3;
  localparam int BUBBLE_W    = 4;
  localparam int PC_W        = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset (count -> 0)
//     clr  : synchronous clear, wins over a same-cycle increment
//     inc  : add one this cycle unless already at all-ones
//     cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush controller for an in-order pipeline.
//   Parameters:
//     NSTAGE       : stall bus width, bit 0 = IF rising toward WB
//     NREQ         : number of stall request sources
//     REQ_DEPTH    : packed NREQ x DEPTH_W; field i = highest stage held by req i
//     FLUSH_BUBBLE : fetch-hold cycles after a flush (1..15)
//     TIMEOUT      : continuous stall cycles that declare deadlock
//     CNTW         : performance counter width
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     stall_req    : per-source level stall request (combinational path to stall)
//     flush_req    : redirect request, sampled at clk, flush_pc valid with it
//     perf_clr     : clear both performance counters
//     stall        : per-stage hold, bit k freezes stage k
//     flush        : registered one-cycle flush strobe
//     new_pc       : registered redirect target, valid while flush = 1
//     stall_cnt    : saturating count of cycles with any stall bit set
//     flush_cnt    : saturating count of flush cycles
//     deadlock     : sticky timeout flag
//     state_dbg    : current FSM state
//
//   Request protocol: stall_req is a level with no handshake -- a source holds
//   it for as long as it needs the pipe held and the hold takes effect in the
//   same cycle. flush_req is a single-cycle pulse sampled at the clock edge;
//   it is always accepted, and the most recent flush overrides any in progress.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                       NSTAGE       = STALL_W_DEF,
  parameter int                       NREQ         = 2,
  parameter logic [NREQ*DEPTH_W-1:0]  REQ_DEPTH    = {3'd3, 3'd2},
  parameter int                       FLUSH_BUBBLE = 1,
  parameter int                       TIMEOUT      = 1024,
  parameter int                       CNTW         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              perf_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt,
  output logic              deadlock,
  output hz_state_e         state_dbg
);

  localparam int RUNW = $clog2(TIMEOUT + 1);

  hz_state_e             state;
  logic [BUBBLE_W-1:0]   bubble;
  logic [RUNW-1:0]       run_cnt;
  logic [NSTAGE-1:0]     run_stall;
  logic                  stall_any;

  // Bits 0..d set. A depth at or beyond the last stage naturally yields all
  // ones, so oversized REQ_DEPTH entries saturate to a full-pipe hold.
  function automatic logic [NSTAGE-1:0] depth_mask(input logic [DEPTH_W-1:0] d);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (k <= int'(d)) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Stall demanded by the requesters alone.
  always_comb begin
    run_stall = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stall_req[i]) begin
        run_stall = run_stall | depth_mask(REQ_DEPTH[i*DEPTH_W +: DEPTH_W]);
      end
    end
  end

  // FLUSH drops all holds (requests are moot once the pipe is emptied);
  // RECOVER additionally holds IF so no wrong-path fetch escapes.
  always_comb begin
    stall = '0;
    if (!rst) begin
      case (state)
        ST_RUN:     stall = run_stall;
        ST_FLUSH:   stall = '0;
        ST_RECOVER: stall = run_stall | NSTAGE'(1);
        default:    stall = '0;
      endcase
    end
  end

  assign stall_any = |stall;
  assign state_dbg = state;

  // Controller FSM. A flush request in any state restarts the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      flush  <= 1'b0;
      new_pc <= '0;
      bubble <= '0;
    end else begin
      flush <= 1'b0;
      if (flush_req) begin
        state  <= ST_FLUSH;
        flush  <= 1'b1;
        new_pc <= flush_pc;
        bubble <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            state <= ST_RUN;
          end
          ST_FLUSH: begin
            state  <= ST_RECOVER;
            bubble <= BUBBLE_W'(FLUSH_BUBBLE);
          end
          ST_RECOVER: begin
            // bubble holds the cycles remaining including this one
            if (bubble <= BUBBLE_W'(1)) begin
              state  <= ST_RUN;
              bubble <= '0;
            end else begin
              bubble <= bubble - 1'b1;
            end
          end
          default: begin
            state  <= ST_RUN;
            bubble <= '0;
          end
        endcase
      end
    end
  end

  // Continuous-stall watchdog. deadlock rises on the same edge at which the
  // run length reaches TIMEOUT; the run counter parks there afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      deadlock <= 1'b0;
    end else begin
      if (!stall_any) begin
        run_cnt <= '0;
      end else if (run_cnt != RUNW'(TIMEOUT)) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (stall_any && (run_cnt == RUNW'(TIMEOUT - 1))) begin
        deadlock <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall_any),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (state == ST_FLUSH),
    .cnt (flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6, SHALL set stall vector width; bit 0 = IF, rising toward WB.
REQ-002 Parameter NREQ, default 2, SHALL set the number of stall request sources.
REQ-003 Parameter REQ_DEPTH, default {3'd3,3'd2}, SHALL be a packed NREQ*3-bit vector; entry i = highest stage index held by request i.
REQ-004 Parameter FLUSH_BUBBLE, default 1, SHALL set the post-flush fetch-hold cycles (1..15).
REQ-005 Parameter TIMEOUT, default 1024, SHALL set the continuous-stall cycles that declare deadlock.
REQ-006 Parameter CNTW, default 32, SHALL set the performance counter width.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 stall_req  in  NREQ  per-source stall request, level, combinational from the requester.
REQ-010 flush_req  in  1  exception/redirect request, sampled at clk.
REQ-011 flush_pc  in  32  redirect target, valid with flush_req.
REQ-012 perf_clr  in  1  clear both performance counters.
REQ-013 stall  out  NSTAGE  per-stage hold; bit k = 1 freezes stage k.
REQ-014 flush  out  1  registered one-cycle pipeline flush strobe.
REQ-015 new_pc  out  32  registered redirect target, valid while flush = 1.
REQ-016 stall_cnt  out  CNTW  saturating count of cycles with any stall bit set.
REQ-017 flush_cnt  out  CNTW  saturating count of flush strobes.
REQ-018 deadlock  out  1  sticky timeout flag.

Function
REQ-019 In RUN, stall SHALL be the combinational OR over asserted stall_req[i] of mask with bits 0..REQ_DEPTH[i] set, zero latency.
REQ-020 FSM states SHALL be RUN, FLUSH, RECOVER.
REQ-021 RUN with flush_req = 1 at clk SHALL enter FLUSH, registering flush = 1 and new_pc = flush_pc in the same edge.
REQ-022 FLUSH SHALL last exactly one cycle, stall SHALL be all zero, and the next state SHALL be RECOVER.
REQ-023 RECOVER SHALL last FLUSH_BUBBLE cycles via a down-counter; stall SHALL be the RUN stall value OR bit 0; it then returns to RUN.
REQ-024 flush_req in FLUSH or RECOVER SHALL re-enter FLUSH with the new flush_pc and restart the bubble count (newest flush wins).
REQ-025 stall_req SHALL be ignored during FLUSH.
REQ-026 flush SHALL be 0 in every state except FLUSH; new_pc SHALL hold its last value outside FLUSH.
REQ-027 A run counter SHALL increment each cycle stall != 0 and clear on any cycle stall == 0.
REQ-028 When the run counter reaches TIMEOUT, deadlock SHALL set on the next edge and hold until rst.
REQ-029 stall_cnt SHALL increment by 1 per cycle with stall != 0 and saturate at all-ones; flush_cnt SHALL increment per FLUSH cycle and saturate the same way.
REQ-030 perf_clr SHALL zero both counters on the next edge; it wins over a same-cycle increment and does not clear deadlock.
REQ-031 REQ_DEPTH entries >= NSTAGE SHALL saturate to mask all ones.

Reset
REQ-032 rst SHALL override all inputs; on the following edge: state RUN, flush 0, new_pc 0, stall_cnt 0, flush_cnt 0, deadlock 0, run and bubble counters 0.
REQ-033 While rst = 1, stall SHALL be combinationally all zero.
REQ-034 rst during FLUSH or RECOVER SHALL abort the sequence with no further flush strobe.

Structure
REQ-035 StallBus width, FSM state encodings and the REQ_DEPTH field width SHALL live in the shared defines header.
REQ-036 The saturating counter with clear SHALL be one sub-module, sat_counter, instantiated twice.

Verification (defaults)
REQ-037 stall_req = 2'b01 -> stall = 6'b000111 in the same cycle; 2'b10 -> 6'b001111; 2'b11 -> 6'b001111.
REQ-038 flush_req = 1, flush_pc = 0xBFC00380 for one cycle -> next cycle flush = 1, new_pc = 0xBFC00380, stall = 0; the following cycle flush = 0, stall = 6'b000001.
REQ-039 flush_req again in RECOVER with 0x80000000 -> second one-cycle flush strobe with new_pc = 0x80000000; flush_cnt = 2.
REQ-040 stall_req = 2'b10 held 1024 cycles -> deadlock = 1 after cycle 1024 and stays 1 after stall_req drops; stall_cnt = 1024.
REQ-041 CNTW = 4, stall held 20 cycles -> stall_cnt = 15; perf_clr with stall still active -> stall_cnt = 0 the next cycle.
REQ-042 rst asserted in FLUSH -> next cycle state RUN, flush = 0, all counters and deadlock = 0.
